uart_frame_rsp: RTL

- Consumer end of the uart_rx byte interface (rx_data/po_flag): parses host command frames and builds response frames.
- Drives the uart_tx byte interface (tx_data/tx_trig).
- Sits between uart_rx and uart_tx in top, replacing the raw loopback with a framed command/response protocol.
- Frame format: SOF 0xA5, CMD, LEN, LEN payload bytes, CHK. CHK is the XOR of CMD, LEN and all payload bytes.

---
 rtl/uart_pkg.sv | 46 ++++
 rtl/frame_buf.sv | 35 +++
 rtl/uart_frame_rsp.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the framed UART command/response
// block (uart_frame_rsp) and its payload buffer (frame_buf).
//
// Contents:
//   - Frame delimiter, command, response and NAK codes.
//   - FSM state encodings (3-bit constants, exposed on fsm_state).
//   - Response kind selector and a saturating increment helper.
package uart_pkg;

    // Frame constants
    localparam logic [7:0] SOF        = 8'hA5;

    localparam logic [7:0] CMD_ECHO   = 8'h01;
    localparam logic [7:0] CMD_STATUS = 8'h02;

    localparam logic [7:0] RSP_ECHO   = 8'h81;
    localparam logic [7:0] RSP_STATUS = 8'h82;
    localparam logic [7:0] RSP_NAK    = 8'h7F;

    localparam logic [7:0] NAK_BADCMD = 8'h01;
    localparam logic [7:0] NAK_BADCHK = 8'h02;
    localparam logic [7:0] NAK_BADLEN = 8'h03;

    // FSM state encodings
    localparam logic [2:0] ST_HUNT  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_LEN   = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_CHK   = 3'd4;
    localparam logic [2:0] ST_BUILD = 3'd5;
    localparam logic [2:0] ST_SEND  = 3'd6;
    localparam logic [2:0] ST_GAP   = 3'd7;

    // Which payload source the response serializer reads from
    typedef enum logic [1:0] {
        RK_ECHO   = 2'd0,
        RK_STATUS = 2'd1,
        RK_NAK    = 2'd2
    } rsp_kind_t;

    // Increment that sticks at 0xFF
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/frame_buf.sv
// frame_buf: DEPTH x 8 register-file payload buffer.
// One synchronous write port, one asynchronous (combinational) read port.
// Storage is intentionally not reset; contents are only read after being
// written by the current frame.
//
// Ports:
//   clk    - clock, write on rising edge
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
module frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_rsp.sv
// uart_frame_rsp: parses host command frames arriving on the uart_rx byte
// interface and answers with response frames on the uart_tx byte interface.
//
// Frame: SOF(0xA5) CMD LEN payload[LEN] CHK, CHK = XOR(CMD, LEN, payload).
// Commands: 0x01 ECHO, 0x02 STATUS; anything else, a bad checksum or an
// oversized LEN is answered with a NAK frame.
//
// Byte interfaces (strobe semantics): a byte is transferred in exactly the
// cycle its strobe is high; there is no back-pressure. rx_data is sampled
// only when po_flag=1. tx_data is updated in the same cycle tx_trig pulses
// and then held until the next tx_trig. Input strobes that arrive while a
// response is in progress (rsp_busy=1) are dropped.
//
// Optional build macro: RX_TIMEOUT_EN adds an inter-byte timeout inside a
// frame (TIMEOUT_CYCLES); a timed-out frame is dropped, counted as an error
// and not answered. Without the macro a partial frame waits indefinitely.
//
// Ports:
//   sclk      - system clock (rising edge)
//   reset     - asynchronous active-low reset
//   rx_data   - received byte, valid while po_flag=1
//   po_flag   - one-cycle received-byte strobe
//   tx_data   - response byte to transmit
//   tx_trig   - one-cycle transmit start strobe
//   rsp_busy  - high from BUILD through the end of the final GAP
//   frame_ok  - one-cycle pulse per accepted good frame
//   frame_err - one-cycle pulse per NAK (or timeout) condition
//   frame_cnt - good frame count, wraps
//   err_cnt   - error count, saturates at 0xFF
//   fsm_state - current FSM state (debug observation)
module uart_frame_rsp
    import uart_pkg::*;
#(
    parameter int MAX_LEN        = 16,
    parameter int TX_GAP         = 52080
`ifdef RX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 104160
`endif
) (
    input  logic       sclk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       po_flag,
    output logic [7:0] tx_data,
    output logic       tx_trig,
    output logic       rsp_busy,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [7:0] frame_cnt,
    output logic [7:0] err_cnt,
    output logic [2:0] fsm_state
);

    localparam int          AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [31:0] GAP_LAST  = 32'(TX_GAP - 1);

    logic [2:0]    state;

    // Receive side
    logic [7:0]    cmd;
    logic [7:0]    len;
    logic [7:0]    chk;
    logic [7:0]    nak_code;   // 0 means the frame is good
    logic [7:0]    rx_cnt;
    logic [AW-1:0] wr_ptr;

    // Response side
    rsp_kind_t     rsp_kind;
    logic [7:0]    rsp_cmd;
    logic [7:0]    rsp_len;
    logic [7:0]    stat0;
    logic [7:0]    stat1;
    logic [7:0]    tx_idx;     // position within the response frame
    logic [AW-1:0] rd_ptr;     // position within the response payload
    logic [7:0]    tx_chk;
    logic [31:0]   gap_cnt;
    logic          last_sent;

    logic [7:0]    buf_rdata;
    logic [7:0]    tx_byte;
    logic          is_last;
    logic          buf_we;

`ifdef RX_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmr;
    logic        in_frame;
    assign in_frame = (state == ST_CMD) || (state == ST_LEN) ||
                      (state == ST_DATA) || (state == ST_CHK);
`endif

    assign buf_we    = (state == ST_DATA) && po_flag;
    assign rsp_busy  = (state == ST_BUILD) || (state == ST_SEND) || (state == ST_GAP);
    assign fsm_state = state;
    assign is_last   = (tx_idx == rsp_len + 8'd3);

    frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk   (sclk),
        .we    (buf_we),
        .waddr (wr_ptr),
        .wdata (rx_data),
        .raddr (rd_ptr),
        .rdata (buf_rdata)
    );

    // Response byte at the current frame position. The chk byte is the
    // accumulated XOR of everything sent after SOF.
    always_comb begin
        tx_byte = 8'h00;
        if (tx_idx == 8'd0) begin
            tx_byte = SOF;
        end else if (tx_idx == 8'd1) begin
            tx_byte = rsp_cmd;
        end else if (tx_idx == 8'd2) begin
            tx_byte = rsp_len;
        end else if (is_last) begin
            tx_byte = tx_chk;
        end else begin
            case (rsp_kind)
                RK_ECHO:   tx_byte = buf_rdata;
                RK_STATUS: tx_byte = (rd_ptr == '0) ? stat0 : stat1;
                default:   tx_byte = nak_code;
            endcase
        end
    end

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state     <= ST_HUNT;
            cmd       <= 8'h00;
            len       <= 8'h00;
            chk       <= 8'h00;
            nak_code  <= 8'h00;
            rx_cnt    <= 8'h00;
            wr_ptr    <= '0;
            rsp_kind  <= RK_ECHO;
            rsp_cmd   <= 8'h00;
            rsp_len   <= 8'h00;
            stat0     <= 8'h00;
            stat1     <= 8'h00;
            tx_idx    <= 8'h00;
            rd_ptr    <= '0;
            tx_chk    <= 8'h00;
            gap_cnt   <= 32'd0;
            last_sent <= 1'b0;
            tx_data   <= 8'h00;
            tx_trig   <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= 8'h00;
            err_cnt   <= 8'h00;
`ifdef RX_TIMEOUT_EN
            tmr       <= 32'd0;
`endif
        end else begin
            tx_trig   <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                ST_HUNT: begin
                    if (po_flag && (rx_data == SOF)) begin
                        state <= ST_CMD;
                    end
                end

                ST_CMD: begin
                    if (po_flag) begin
                        cmd      <= rx_data;
                        chk      <= rx_data;
                        nak_code <= 8'h00;
                        state    <= ST_LEN;
                    end
                end

                ST_LEN: begin
                    if (po_flag) begin
                        len    <= rx_data;
                        chk    <= chk ^ rx_data;
                        rx_cnt <= 8'h00;
                        wr_ptr <= '0;
                        if (rx_data > MAX_LEN_B) begin
                            // Rest of the frame is left for HUNT to discard
                            nak_code <= NAK_BADLEN;
                            state    <= ST_BUILD;
                        end else if (rx_data == 8'h00) begin
                            state <= ST_CHK;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (po_flag) begin
                        chk    <= chk ^ rx_data;
                        rx_cnt <= rx_cnt + 8'd1;
                        wr_ptr <= wr_ptr + AW'(1);
                        if (rx_cnt + 8'd1 == len) begin
                            state <= ST_CHK;
                        end
                    end
                end

                ST_CHK: begin
                    if (po_flag) begin
                        if (rx_data != chk) begin
                            nak_code <= NAK_BADCHK;
                        end else if ((cmd == CMD_ECHO) || (cmd == CMD_STATUS)) begin
                            nak_code <= 8'h00;
                        end else begin
                            nak_code <= NAK_BADCMD;
                        end
                        state <= ST_BUILD;
                    end
                end

                ST_BUILD: begin
                    tx_idx <= 8'h00;
                    rd_ptr <= '0;
                    tx_chk <= 8'h00;
                    if (nak_code != 8'h00) begin
                        rsp_kind  <= RK_NAK;
                        rsp_cmd   <= RSP_NAK;
                        rsp_len   <= 8'd1;
                        frame_err <= 1'b1;
                        err_cnt   <= sat_inc8(err_cnt);
                    end else begin
                        if (cmd == CMD_ECHO) begin
                            rsp_kind <= RK_ECHO;
                            rsp_cmd  <= RSP_ECHO;
                            rsp_len  <= len;
                        end else begin
                            // Snapshot taken before this frame's increment
                            rsp_kind <= RK_STATUS;
                            rsp_cmd  <= RSP_STATUS;
                            rsp_len  <= 8'd2;
                            stat0    <= frame_cnt;
                            stat1    <= err_cnt;
                        end
                        frame_ok  <= 1'b1;
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                    state <= ST_SEND;
                end

                ST_SEND: begin
                    tx_data   <= tx_byte;
                    tx_trig   <= 1'b1;
                    tx_idx    <= tx_idx + 8'd1;
                    last_sent <= is_last;
                    gap_cnt   <= 32'd0;
                    if ((tx_idx != 8'd0) && !is_last) begin
                        tx_chk <= tx_chk ^ tx_byte;
                    end
                    if ((tx_idx >= 8'd3) && !is_last) begin
                        rd_ptr <= rd_ptr + AW'(1);
                    end
                    state <= ST_GAP;
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= last_sent ? ST_HUNT : ST_SEND;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end

                default: state <= ST_HUNT;
            endcase

`ifdef RX_TIMEOUT_EN
            // Inter-byte timer; overrides the case above only on idle cycles,
            // where the case leaves the state unchanged.
            if (!in_frame || po_flag) begin
                tmr <= 32'd0;
            end else if (tmr == TO_LAST) begin
                tmr       <= 32'd0;
                state     <= ST_HUNT;
                frame_err <= 1'b1;
                err_cnt   <= sat_inc8(err_cnt);
            end else begin
                tmr <= tmr + 32'd1;
            end
`endif
        end
    end

endmodule
